// File: rtl/uart_gate_pkg.sv
// Shared definitions for the gate frame packer/unpacker: frame constants,
// the framing FSM state type and a one-byte CRC8 step (MSB-first).
package uart_gate_pkg;

    localparam int unsigned FRAME_LEN       = 32;
    localparam int unsigned PAYLOAD_LEN_DEF = FRAME_LEN - 6;

    localparam logic [7:0] HDR0         = 8'h55;
    localparam logic [7:0] HDR1         = 8'hBB;
    localparam logic [7:0] HDR2         = 8'h03;
    localparam logic [7:0] HDR3         = 8'h1A;
    localparam logic [7:0] TAIL_BYTE    = 8'hF0;
    localparam logic [7:0] CRC_POLY_DEF = 8'h07;

    typedef enum logic [2:0] {
        StHunt0,
        StHunt1,
        StHdr2,
        StHdr3,
        StPayld,
        StCrc,
        StTail
    } gate_state_e;

    // Fold one byte into a CRC8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_d8_rx.sv
// Byte-wide CRC8 accumulator: one byte per cycle, synchronous clear (clr wins over din_vld).
module crc8_d8_rx
    import uart_gate_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       din_vld,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    // Next CRC value: clear, fold the new byte, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (din_vld) begin
            crc_d = crc8_byte(crc_q, din, POLY);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/uart_gate_unpack.sv
// Gate frame unpacker: hunts for 55 BB 03 1A | payload | CRC8 | F0 in the received byte
// stream and publishes good payloads with a one-cycle frame_vld pulse.
// Optional inter-byte idle timeout is built when UART_UNPACK_TIMEOUT_EN is defined.
module uart_gate_unpack
    import uart_gate_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = PAYLOAD_LEN_DEF,
    parameter logic [7:0]  CRC_POLY    = CRC_POLY_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [7:0]               rd_data,
    output logic [8*PAYLOAD_LEN-1:0] rx_payload,
    output logic                     frame_vld,
    output logic                     crc_err,
    output logic                     tail_err,
    output logic                     timeout_err,
    output logic [7:0]               err_cnt
);

    localparam int unsigned IdxW = $clog2(PAYLOAD_LEN);

    gate_state_e              state_q, state_d, cur_state;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [8*PAYLOAD_LEN-1:0] shadow_q, shadow_d, rx_payload_q, rx_payload_d;
    logic [7:0]               rx_crc_q, rx_crc_d, err_cnt_q, err_cnt_d, crc_calc;
    logic                     frame_vld_q, frame_vld_d, crc_err_q, crc_err_d;
    logic                     tail_err_q, tail_err_d;
    logic                     expire, crc_clr, crc_vld;

    crc8_d8_rx #(
        .POLY(CRC_POLY)
    ) u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .din_vld(crc_vld),
        .din    (rd_data),
        .crc    (crc_calc)
    );

`ifdef UART_UNPACK_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             timeout_err_q;

    // Idle timer: runs outside HUNT0, restarts on every byte and on expiry.
    always_comb begin
        expire = (state_q != StHunt0) && (idle_q == IdleW'(TIMEOUT_CYC - 1));
        if (rd_en || expire || (state_q == StHunt0)) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle timer and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            timeout_err_q <= expire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign expire      = 1'b0;
    // No timer in this build; the parameter only sizes the timer when it exists.
    assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // Framing FSM, payload capture and frame evaluation on the tail byte.
    always_comb begin
        // A byte arriving on the expiry cycle is treated as the first hunt byte.
        cur_state    = expire ? StHunt0 : state_q;
        state_d      = cur_state;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        rx_crc_d     = rx_crc_q;
        rx_payload_d = rx_payload_q;
        frame_vld_d  = 1'b0;
        crc_err_d    = 1'b0;
        tail_err_d   = 1'b0;
        crc_vld      = 1'b0;
        if (rd_en) begin
            unique case (cur_state)
                StHunt0: begin
                    if (rd_data == HDR0) state_d = StHunt1;
                end
                StHunt1: begin
                    if (rd_data == HDR1)      state_d = StHdr2;
                    else if (rd_data != HDR0) state_d = StHunt0;
                end
                StHdr2: begin
                    if (rd_data == HDR2) begin
                        state_d = StHdr3;
                        crc_vld = 1'b1;
                    end else begin
                        state_d = (rd_data == HDR0) ? StHunt1 : StHunt0;
                    end
                end
                StHdr3: begin
                    if (rd_data == HDR3) begin
                        state_d = StPayld;
                        crc_vld = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = (rd_data == HDR0) ? StHunt1 : StHunt0;
                    end
                end
                StPayld: begin
                    shadow_d[8*int'(idx_q) +: 8] = rd_data;
                    crc_vld = 1'b1;
                    if (idx_q == IdxW'(PAYLOAD_LEN - 1)) begin
                        state_d = StCrc;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StCrc: begin
                    rx_crc_d = rd_data;
                    state_d  = StTail;
                end
                StTail: begin
                    // CRC mismatch outranks a bad tail byte.
                    if (crc_calc != rx_crc_q) begin
                        crc_err_d = 1'b1;
                    end else if (rd_data != TAIL_BYTE) begin
                        tail_err_d = 1'b1;
                    end else begin
                        frame_vld_d  = 1'b1;
                        rx_payload_d = shadow_q;
                    end
                    state_d = StHunt0;
                end
                default: state_d = StHunt0;
            endcase
        end
        crc_clr = (state_d == StHunt0) || (state_d == StHunt1);
        if ((crc_err_d || tail_err_d || expire) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHunt0;
            idx_q        <= '0;
            shadow_q     <= '0;
            rx_payload_q <= '0;
            rx_crc_q     <= 8'h00;
            err_cnt_q    <= 8'h00;
            frame_vld_q  <= 1'b0;
            crc_err_q    <= 1'b0;
            tail_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            rx_payload_q <= rx_payload_d;
            rx_crc_q     <= rx_crc_d;
            err_cnt_q    <= err_cnt_d;
            frame_vld_q  <= frame_vld_d;
            crc_err_q    <= crc_err_d;
            tail_err_q   <= tail_err_d;
        end
    end

    assign rx_payload = rx_payload_q;
    assign frame_vld  = frame_vld_q;
    assign crc_err    = crc_err_q;
    assign tail_err   = tail_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_gate_unpack.sv
// Directed bench for uart_gate_unpack; the timeout scenario runs when
// UART_UNPACK_TIMEOUT_EN is defined (TIMEOUT_CYC = 50).
module tb_uart_gate_unpack;

    localparam int unsigned PL = 26;
`ifdef UART_UNPACK_TIMEOUT_EN
    localparam int unsigned TO = 50;
`else
    localparam int unsigned TO = 100000;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_en;
    logic [7:0]      rd_data;
    logic [8*PL-1:0] rx_payload;
    logic            frame_vld, crc_err, tail_err, timeout_err;
    logic [7:0]      err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int to_cnt   = 0;
    int exp_err  = 0;
    logic [8*PL-1:0] exp_pl;

    uart_gate_unpack #(
        .PAYLOAD_LEN(PL),
        .CRC_POLY   (8'h07),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_payload (rx_payload),
        .frame_vld  (frame_vld),
        .crc_err    (crc_err),
        .tail_err   (tail_err),
        .timeout_err(timeout_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_vld)   vld_cnt++;
        if (timeout_err) to_cnt++;
    end

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    function automatic logic [8*PL-1:0] make_pl(input logic [7:0] base);
        logic [8*PL-1:0] r;
        for (int i = 0; i < PL; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rd_en   = 1'b1;
        rd_data = b;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] base, input int n);
        send_byte(8'h55); send_byte(8'hBB); send_byte(8'h03); send_byte(8'h1A);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    endtask

    // Full frame; flip_idx >= 0 corrupts that payload byte after the CRC is computed.
    task automatic send_frame(input logic [7:0] base, input int flip_idx, input logic [7:0] tail_b,
                              input int stall_after);
        logic [7:0] c;
        c = crc_step(8'h00, 8'h03);
        c = crc_step(c, 8'h1A);
        for (int i = 0; i < PL; i++) c = crc_step(c, base + 8'(i));
        send_byte(8'h55); send_byte(8'hBB); send_byte(8'h03); send_byte(8'h1A);
        for (int i = 0; i < PL; i++) begin
            send_byte((i == flip_idx) ? 8'hFF : base + 8'(i));
            if (i == stall_after) repeat (60) @(posedge clk);
            if (i == stall_after) #1;
        end
        send_byte(c);
        send_byte(tail_b);
    endtask

    task automatic test_reset;
        reset = 1'b1; rd_en = 1'b0; rd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (frame_vld !== 1'b0) begin n_fail++; $display("FAIL reset_frame_vld got %b want 0", frame_vld); end
        n_checks++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err got %b want 0", crc_err); end
        n_checks++; if (tail_err !== 1'b0) begin n_fail++; $display("FAIL reset_tail_err got %b want 0", tail_err); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        n_checks++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt got %h want 00", err_cnt); end
        n_checks++; if (rx_payload !== '0) begin n_fail++; $display("FAIL reset_rx_payload got %h want 0", rx_payload); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame;
        exp_pl = make_pl(8'h00);
        send_frame(8'h00, -1, 8'hF0, -1);
        n_checks++; if (frame_vld !== 1'b1) begin n_fail++; $display("FAIL good_frame_vld got %b want 1", frame_vld); end
        n_checks++; if (crc_err !== 1'b0 || tail_err !== 1'b0) begin n_fail++; $display("FAIL good_no_err got crc=%b tail=%b want 0 0", crc_err, tail_err); end
        n_checks++; if (rx_payload[7:0] !== 8'h00) begin n_fail++; $display("FAIL good_byte0 got %h want 00", rx_payload[7:0]); end
        n_checks++; if (rx_payload[8*PL-1 -: 8] !== 8'h19) begin n_fail++; $display("FAIL good_top_byte got %h want 19", rx_payload[8*PL-1 -: 8]); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL good_payload got %h want %h", rx_payload, exp_pl); end
        @(posedge clk); #1;
        n_checks++; if (frame_vld !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width got %b want 0", frame_vld); end
        n_checks++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL good_err_cnt got %h want %h", err_cnt, 8'(exp_err)); end
    endtask

    task automatic test_crc_err;
        int v0;
        v0 = vld_cnt;
        send_frame(8'h00, 10, 8'hF0, -1);
        exp_err++;
        n_checks++; if (crc_err !== 1'b1) begin n_fail++; $display("FAIL crc_err_pulse got %b want 1", crc_err); end
        n_checks++; if (tail_err !== 1'b0) begin n_fail++; $display("FAIL crc_err_no_tail got %b want 0", tail_err); end
        @(posedge clk); #1;
        n_checks++; if (vld_cnt !== v0) begin n_fail++; $display("FAIL crc_err_no_vld got %0d want %0d", vld_cnt, v0); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL crc_err_payload_held got %h want %h", rx_payload, exp_pl); end
        n_checks++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL crc_err_cnt got %h want %h", err_cnt, 8'(exp_err)); end
    endtask

    task automatic test_tail_err;
        int v0;
        v0 = vld_cnt;
        send_frame(8'h20, -1, 8'hF1, -1);
        exp_err++;
        n_checks++; if (tail_err !== 1'b1) begin n_fail++; $display("FAIL tail_err_pulse got %b want 1", tail_err); end
        n_checks++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL tail_err_no_crc got %b want 0", crc_err); end
        @(posedge clk); #1;
        n_checks++; if (vld_cnt !== v0) begin n_fail++; $display("FAIL tail_err_no_vld got %0d want %0d", vld_cnt, v0); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL tail_err_payload_held got %h want %h", rx_payload, exp_pl); end
        n_checks++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL tail_err_cnt got %h want %h", err_cnt, 8'(exp_err)); end
    endtask

    task automatic test_crc_priority;
        send_frame(8'h30, 3, 8'hF1, -1);
        exp_err++;
        n_checks++; if (crc_err !== 1'b1 || tail_err !== 1'b0) begin n_fail++; $display("FAIL crc_priority got crc=%b tail=%b want 1 0", crc_err, tail_err); end
        @(posedge clk); #1;
        n_checks++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL crc_priority_cnt got %h want %h", err_cnt, 8'(exp_err)); end
    endtask

    task automatic test_resync;
        int v0;
        v0 = vld_cnt;
        exp_pl = make_pl(8'h80);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_frame(8'h80, -1, 8'hF0, -1);
        n_checks++; if (frame_vld !== 1'b1) begin n_fail++; $display("FAIL resync_vld got %b want 1", frame_vld); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL resync_payload got %h want %h", rx_payload, exp_pl); end
        @(posedge clk); #1;
        n_checks++; if (vld_cnt !== v0 + 1) begin n_fail++; $display("FAIL resync_vld_count got %0d want %0d", vld_cnt, v0 + 1); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        send_partial(8'h00, 15);
        reset = 1'b1; rd_en = 1'b1; rd_data = 8'h0F;
        @(posedge clk); #1;
        reset = 1'b0; rd_en = 1'b0;
        exp_err = 0;
        v0 = vld_cnt;
        n_checks++; if (rx_payload !== '0) begin n_fail++; $display("FAIL midreset_payload got %h want 0", rx_payload); end
        n_checks++; if (err_cnt !== 8'h00 || crc_err !== 1'b0 || tail_err !== 1'b0) begin n_fail++; $display("FAIL midreset_errs got cnt=%h crc=%b tail=%b want 00 0 0", err_cnt, crc_err, tail_err); end
        exp_pl = make_pl(8'h40);
        send_frame(8'h40, -1, 8'hF0, -1);
        @(posedge clk); #1;
        n_checks++; if (vld_cnt !== v0 + 1) begin n_fail++; $display("FAIL midreset_vld_count got %0d want %0d", vld_cnt, v0 + 1); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL midreset_payload2 got %h want %h", rx_payload, exp_pl); end
    endtask

`ifdef UART_UNPACK_TIMEOUT_EN
    task automatic test_timeout;
        int t0;
        t0 = to_cnt;
        send_partial(8'h00, 13);
        repeat (60) @(posedge clk);
        #1;
        exp_err++;
        n_checks++; if (to_cnt !== t0 + 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want %0d", to_cnt, t0 + 1); end
        n_checks++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL timeout_err_cnt got %h want %h", err_cnt, 8'(exp_err)); end
        exp_pl = make_pl(8'h33);
        send_frame(8'h33, -1, 8'hF0, -1);
        n_checks++; if (frame_vld !== 1'b1) begin n_fail++; $display("FAIL timeout_next_vld got %b want 1", frame_vld); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL timeout_next_payload got %h want %h", rx_payload, exp_pl); end
    endtask
`else
    task automatic test_stall_no_timeout;
        exp_pl = make_pl(8'h33);
        send_frame(8'h33, -1, 8'hF0, 12);
        n_checks++; if (frame_vld !== 1'b1) begin n_fail++; $display("FAIL stall_vld got %b want 1", frame_vld); end
        n_checks++; if (rx_payload !== exp_pl) begin n_fail++; $display("FAIL stall_payload got %h want %h", rx_payload, exp_pl); end
        n_checks++; if (to_cnt !== 0) begin n_fail++; $display("FAIL stall_timeout_pulses got %0d want 0", to_cnt); end
    endtask
`endif

    task automatic test_err_saturation;
        while (exp_err < 255) begin
            send_frame(8'h10, 0, 8'hF0, -1);
            exp_err++;
        end
        @(posedge clk); #1;
        n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_reach got %h want ff", err_cnt); end
        send_frame(8'h10, 0, 8'hF0, -1);
        n_checks++; if (crc_err !== 1'b1) begin n_fail++; $display("FAIL sat_crc_pulse got %b want 1", crc_err); end
        @(posedge clk); #1;
        n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_hold got %h want ff", err_cnt); end
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; rd_data = 8'h00;
        test_reset();
        test_good_frame();
        test_crc_err();
        test_tail_err();
        test_crc_priority();
        test_resync();
        test_reset_mid_frame();
`ifdef UART_UNPACK_TIMEOUT_EN
        test_timeout();
`else
        test_stall_no_timeout();
`endif
        test_err_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
